// File: rtl/iomem_arbiter.sv
// iomem_arbiter: round-robin arbiter of two iomem masters onto one peripheral bus with access timeout
module iomem_arbiter #(
    parameter int          TIMEOUT   = 64,
    parameter logic [31:0] ERR_RDATA = 32'hFFFF_FFFF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        m0_valid,
    input  logic [3:0]  m0_wstrb,
    input  logic [31:0] m0_addr,
    input  logic [31:0] m0_wdata,
    output logic        m0_ready,
    output logic [31:0] m0_rdata,
    input  logic        m1_valid,
    input  logic [3:0]  m1_wstrb,
    input  logic [31:0] m1_addr,
    input  logic [31:0] m1_wdata,
    output logic        m1_ready,
    output logic [31:0] m1_rdata,
    output logic        s_valid,
    output logic [3:0]  s_wstrb,
    output logic [31:0] s_addr,
    output logic [31:0] s_wdata,
    input  logic        s_ready,
    input  logic [31:0] s_rdata,
    output logic        busy,
    output logic [7:0]  timeout_count
);
    typedef enum logic [1:0] {IDLE, BUS, RESP} state_t;

    localparam logic [7:0] LAST_CNT = 8'(TIMEOUT - 1);

    state_t      state_q, state_d;
    logic        grant_q, grant_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [7:0]  tcount_q, tcount_d;
    logic        s_valid_q, s_valid_d;
    logic [3:0]  s_wstrb_q, s_wstrb_d;
    logic [31:0] s_addr_q, s_addr_d;
    logic [31:0] s_wdata_q, s_wdata_d;
    logic        m0_ready_q, m0_ready_d;
    logic        m1_ready_q, m1_ready_d;
    logic [31:0] m0_rdata_q, m0_rdata_d;
    logic [31:0] m1_rdata_q, m1_rdata_d;
    logic        pick;
    logic        done;
    logic [31:0] done_data;

    // on a tie the master not granted last wins; grant_q doubles as last_grant
    assign pick      = (m0_valid && m1_valid) ? ~grant_q : m1_valid;
    assign done      = s_ready || cnt_q == LAST_CNT;
    assign done_data = s_ready ? s_rdata : ERR_RDATA;

    assign busy          = state_q != IDLE;
    assign timeout_count = tcount_q;
    assign s_valid       = s_valid_q;
    assign s_wstrb       = s_wstrb_q;
    assign s_addr        = s_addr_q;
    assign s_wdata       = s_wdata_q;
    assign m0_ready      = m0_ready_q;
    assign m1_ready      = m1_ready_q;
    assign m0_rdata      = m0_rdata_q;
    assign m1_rdata      = m1_rdata_q;

    // next state: grant in IDLE, complete or abort in BUS, one-cycle ready pulse in RESP
    always_comb begin
        state_d    = state_q;
        grant_d    = grant_q;
        cnt_d      = cnt_q;
        tcount_d   = tcount_q;
        s_valid_d  = s_valid_q;
        s_wstrb_d  = s_wstrb_q;
        s_addr_d   = s_addr_q;
        s_wdata_d  = s_wdata_q;
        m0_rdata_d = m0_rdata_q;
        m1_rdata_d = m1_rdata_q;
        m0_ready_d = 1'b0;
        m1_ready_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (m0_valid || m1_valid) begin
                    state_d   = BUS;
                    grant_d   = pick;
                    cnt_d     = 8'd0;
                    s_valid_d = 1'b1;
                    s_wstrb_d = pick ? m1_wstrb : m0_wstrb;
                    s_addr_d  = pick ? m1_addr : m0_addr;
                    s_wdata_d = pick ? m1_wdata : m0_wdata;
                end
            end
            BUS: begin
                if (done) begin
                    state_d    = RESP;
                    s_valid_d  = 1'b0;
                    m0_ready_d = !grant_q;
                    m1_ready_d = grant_q;
                    m0_rdata_d = grant_q ? m0_rdata_q : done_data;
                    m1_rdata_d = grant_q ? done_data : m1_rdata_q;
                    tcount_d   = (!s_ready && tcount_q != 8'hFF) ? tcount_q + 8'd1 : tcount_q;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // state registers; reset abandons any access in flight
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            grant_q    <= 1'b1;
            cnt_q      <= 8'd0;
            tcount_q   <= 8'd0;
            s_valid_q  <= 1'b0;
            s_wstrb_q  <= 4'd0;
            s_addr_q   <= 32'd0;
            s_wdata_q  <= 32'd0;
            m0_ready_q <= 1'b0;
            m1_ready_q <= 1'b0;
            m0_rdata_q <= 32'd0;
            m1_rdata_q <= 32'd0;
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            cnt_q      <= cnt_d;
            tcount_q   <= tcount_d;
            s_valid_q  <= s_valid_d;
            s_wstrb_q  <= s_wstrb_d;
            s_addr_q   <= s_addr_d;
            s_wdata_q  <= s_wdata_d;
            m0_ready_q <= m0_ready_d;
            m1_ready_q <= m1_ready_d;
            m0_rdata_q <= m0_rdata_d;
            m1_rdata_q <= m1_rdata_d;
        end
    end
endmodule

// File: doc/iomem_arbiter.md
IOMEM_ARBITER -- requirements
Module: iomem_arbiter

Interface
REQ-001 Parameter TIMEOUT, default 64, SHALL set the maximum number of cycles a peripheral access may stay in BUS before abort; legal range 2..255.
REQ-002 Parameter ERR_RDATA, default 32'hFFFF_FFFF, SHALL be the read data returned to a master on timeout abort.
REQ-003 clk  input  1  sole clock; all state SHALL update on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 m0_valid/m0_wstrb/m0_addr/m0_wdata  input  1/4/32/32  master 0 request (CPU iomem port).
REQ-006 m0_ready/m0_rdata  output  1/32  master 0 completion pulse and read data.
REQ-007 m1_valid/m1_wstrb/m1_addr/m1_wdata  input  1/4/32/32  master 1 request (debug/DMA port).
REQ-008 m1_ready/m1_rdata  output  1/32  master 1 completion pulse and read data.
REQ-009 s_valid/s_wstrb/s_addr/s_wdata  output  1/4/32/32  shared peripheral bus request, all registered.
REQ-010 s_ready/s_rdata  input  1/32  peripheral completion and read data.
REQ-011 busy  output  1  high in any state other than IDLE.
REQ-012 timeout_count  output  8  saturating count of aborted accesses.

Function
REQ-013 The FSM SHALL have states IDLE, BUS, RESP; reset state IDLE.
REQ-014 In IDLE with any mX_valid high, the arbiter SHALL grant, capture that master's wstrb/addr/wdata into s_* registers, set s_valid=1, clear the timeout counter and enter BUS on the same edge.
REQ-015 Arbitration SHALL be round-robin: with both valid, grant the master not granted last; last_grant resets to 1 so m0 wins the first tie.
REQ-016 With a single valid master, that master SHALL be granted regardless of last_grant.
REQ-017 s_wstrb/s_addr/s_wdata SHALL remain stable for the whole BUS state; master inputs SHALL be ignored after capture.
REQ-018 In BUS, s_ready=1 sampled SHALL clear s_valid, latch s_rdata into the granted master's mX_rdata, and enter RESP.
REQ-019 In BUS without s_ready, the counter SHALL increment; when it equals TIMEOUT-1 the arbiter SHALL clear s_valid, load ERR_RDATA into the granted mX_rdata, increment timeout_count (saturating at 255) and enter RESP.
REQ-020 s_ready and timeout in the same cycle: s_ready SHALL win; timeout_count is unchanged.
REQ-021 In RESP, the granted mX_ready SHALL be high for exactly one cycle, then the FSM SHALL return to IDLE; the non-granted mX_ready SHALL stay 0.
REQ-022 Latency: request sampled at edge N gives s_valid high from cycle N+1; a slave with one-cycle response gives mX_ready high in cycle N+3.
REQ-023 A granted master dropping valid before ready SHALL NOT abort the access; it completes normally.
REQ-024 s_ready outside BUS SHALL be ignored.
REQ-025 mX_rdata SHALL hold its value until the next completion for that master.

Reset
REQ-026 reset SHALL force IDLE, s_valid=0, m0_ready=m1_ready=0, last_grant=1, counter=0, timeout_count=0, m0_rdata=m1_rdata=s_wstrb=s_addr=s_wdata=0.
REQ-027 reset asserted in BUS or RESP SHALL abandon the access with no mX_ready pulse, and reset SHALL take priority over all other events.

Verification
REQ-028 m0 write addr 32'h0300_0000, wdata 32'h0000_00A5, wstrb 4'hF; slave ready 1 cycle after s_valid -> s_addr/s_wdata match, m0_ready one-cycle pulse in cycle N+3, m1_ready stays 0.
REQ-029 m0 and m1 both valid in IDLE after reset -> m0 first, then m1, then m0 again on the next tie.
REQ-030 m1 read, slave returns 32'h1234_5678 -> m1_rdata=32'h1234_5678 during m1_ready pulse, m0_rdata unchanged.
REQ-031 TIMEOUT=4, slave never ready -> s_valid high for 4 cycles, m0_rdata=32'hFFFF_FFFF with m0_ready, timeout_count=1; 300 such aborts -> timeout_count=255.
REQ-032 s_ready arriving in the cycle the counter hits TIMEOUT-1 -> real s_rdata returned, timeout_count unchanged.
REQ-033 reset pulsed while in BUS -> next cycle s_valid=0, busy=0, no mX_ready pulse, next tie grants m0.
